// File: rtl/mult_issue.sv
// Operand sequencer and result collector around a pipelined 32x32 multiplier.
// Define MULT_ISSUE_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
//
// state | meaning
// IDLE  | no issue this cycle, operand register held on mul_a/mul_b
// LO    | issuing the latched pair for the low product half
// HI    | issuing the latched pair for the high product half
module mult_issue #(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_s,
  input  logic [31:0] mul_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_p,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t            state;
  logic              accept;
  logic              pop;
  logic              push;
  logic [CW-1:0]     credit;
  logic [31:0]       a_mag;
  logic [31:0]       b_mag;
  logic [LATENCY-1:0] lo_pipe;
  logic [LATENCY-1:0] hi_pipe;
  logic [31:0]       lo_hold;
  logic [63:0]       raw_p;
  logic [63:0]       push_data;
  logic [63:0]       mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  assign in_ready  = !reset && (state != LO) && (credit < CREDIT_MAX);
  assign accept    = in_valid && in_ready;
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid && out_ready;
  assign busy      = (credit != '0);
  assign out_p     = mem[rd_ptr[AW-1:0]];
  assign push      = hi_pipe[LATENCY-1];
  assign raw_p     = {mul_c, lo_hold};

`ifdef MULT_ISSUE_SIGNED_EN
  logic               op_sign;
  logic [LATENCY-1:0] sign_pipe;

  // |-2^31| wraps to 0x80000000, which is the correct unsigned magnitude
  assign a_mag     = in_a[31] ? (~in_a + 32'd1) : in_a;
  assign b_mag     = in_b[31] ? (~in_b + 32'd1) : in_b;
  assign push_data = sign_pipe[LATENCY-1] ? (~raw_p + 64'd1) : raw_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_sign   <= 1'b0;
      sign_pipe <= '0;
    end else begin
      if (accept) op_sign <= in_a[31] ^ in_b[31];
      sign_pipe <= {sign_pipe[LATENCY-2:0], op_sign};
    end
  end
`else
  assign a_mag     = in_a;
  assign b_mag     = in_b;
  assign push_data = raw_p;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      mul_s <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= LO;
            mul_s <= 1'b1;
            mul_a <= a_mag;
            mul_b <= b_mag;
          end
        end
        LO: begin
          state <= HI;
          mul_s <= 1'b0;
        end
        HI: begin
          if (accept) begin
            state <= LO;
            mul_s <= 1'b1;
            mul_a <= a_mag;
            mul_b <= b_mag;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          mul_s <= 1'b0;
        end
      endcase
    end
  end

  // Tags travel alongside the multiplier so the tail lines up with mul_c
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_pipe <= '0;
      hi_pipe <= '0;
      lo_hold <= '0;
    end else begin
      lo_pipe <= {lo_pipe[LATENCY-2:0], (state == LO)};
      hi_pipe <= {hi_pipe[LATENCY-2:0], (state == HI)};
      if (lo_pipe[LATENCY-1]) lo_hold <= mul_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= '0;
    end else if (accept && !pop) begin
      credit <= credit + CREDIT_ONE;
    end else if (!accept && pop) begin
      credit <= credit - CREDIT_ONE;
    end
  end

  // Credit bounds outstanding pairs to FIFO_DEPTH, so push never finds the FIFO full
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_mult_issue.sv
// Randomized bench for mult_issue with a 3-cycle multiplier model and a queue-based product reference.
// Honors MULT_ISSUE_SIGNED_EN the same way as the design.
module tb_mult_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_s;
  logic [31:0] mul_c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic        prev_acc = 1'b0;
  logic [31:0] m0, m1, m2;

  always #5 clk = ~clk;

  mult_issue #(.LATENCY(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_s(mul_s), .mul_c(mul_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  // External unsigned multiplier: input registered, then two more stages
  always @(posedge clk) begin
    logic [63:0] full;
    full = {32'b0, mul_a} * {32'b0, mul_b};
    m0 <= mul_s ? full[31:0] : full[63:32];
    m1 <= m0;
    m2 <= m1;
  end
  assign mul_c = m2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ISSUE_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  // Reference: every accepted pair produces exactly one product, in order;
  // in_ready drops the cycle after an accept or when 4 pairs are outstanding.
  always @(negedge clk) begin
    if (reset) begin
      chk("rdy_in_reset", {63'b0, in_ready}, 64'd0);
      q.delete();
      prev_acc = 1'b0;
    end else begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (!prev_acc && q.size() < 4)});
      chk("busy", {63'b0, busy}, {63'b0, (q.size() != 0)});
      if (q.size() == 0) chk("stale", {63'b0, out_valid}, 64'd0);
      if (out_valid && out_ready && q.size() != 0) chk("prod", out_p, q.pop_front());
      if (in_valid && in_ready) q.push_back(ref_prod(in_a, in_b));
      prev_acc = in_valid && in_ready;
    end
  end

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_busy", {63'b0, busy}, 64'd0);
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
    int n;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, out_p, exp);
    drain();
  endtask

  initial begin
    int n, sent, cnt;
    logic [63:0] exp_big;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy",   {63'b0, busy},      64'd0);
    chk("rst_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_muls",   {63'b0, mul_s},     64'd0);
    chk("rst_mula",   {32'b0, mul_a},     64'd0);

    // All-ones operands: timing of the issue and of out_valid
`ifdef MULT_ISSUE_SIGNED_EN
    exp_big = 64'h0000000000000001;
`else
    exp_big = 64'hFFFFFFFE00000001;
`endif
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_accept", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) chk("t1_muls_lo", {63'b0, mul_s}, 64'd1);
      if (i == 2) chk("t1_muls_hi", {63'b0, mul_s}, 64'd0);
      chk("t1_ovalid", {63'b0, out_valid}, {63'b0, (i == 6)});
      if (i == 6) chk("t1_prod", out_p, exp_big);
    end
    drain();

    // Streaming: 8 pairs back to back, in_ready must alternate
    in_a = $urandom; in_b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    sent = 0; n = 0;
    while (sent < 8 && n < 100) begin
      @(negedge clk);
      chk("stream_rdy", {63'b0, in_ready}, {63'b0, (n % 2 == 0)});
      cnt = in_ready ? 1 : 0;
      sent += cnt;
      @(posedge clk); #1;
      if (cnt == 1) begin in_a = $urandom; in_b = $urandom; end
      if (sent == 8) in_valid = 1'b0;
      n++;
    end
    chk("stream_sent", 64'(sent), 64'd8);
    drain();

    // Backpressure: only FIFO_DEPTH pairs admitted while nothing is popped
    out_ready = 1'b0; in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) cnt++;
      @(posedge clk); #1;
      in_a = $urandom; in_b = $urandom;
    end
    chk("bp_accepts", 64'(cnt), 64'd4);
    @(negedge clk);
    chk("bp_full_rdy", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_a = $urandom; in_b = $urandom;
    end
    drain();

    // Random valid/ready traffic
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a = $urandom; in_b = $urandom;
      if (i % 50 == 7) in_a = 32'h80000000;
      if (i % 50 == 9) in_b = 32'hFFFFFFFF;
    end
    drain();

    // Reset one cycle after the HI issue discards the in-flight pair
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    @(negedge clk);
    chk("rs_accept", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rs_ovalid", {63'b0, out_valid}, 64'd0);
    chk("rs_busy",   {63'b0, busy},      64'd0);
    chk("rs_ready",  {63'b0, in_ready},  64'd1);
    repeat (12) @(negedge clk);
    chk("rs_no_stale", {63'b0, out_valid}, 64'd0);

`ifdef MULT_ISSUE_SIGNED_EN
    send_one(32'hFFFFFFFD, 32'd5,       64'hFFFFFFFFFFFFFFF1, "s_m3x5");
    send_one(32'h80000000, 32'h80000000, 64'h4000000000000000, "s_min_sq");
    send_one(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, "s_m1xm1");
`else
    send_one(32'hFFFFFFFD, 32'd5,       64'h00000004FFFFFFF1, "u_fffdx5");
    send_one(32'h80000000, 32'h80000000, 64'h4000000000000000, "u_msb_sq");
`endif
    send_one(32'd0, 32'h12345678, 64'd0, "zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
